// File: rtl/dcache_dma.sv
// Block copy / fill engine that masters the data-cache port with single-word accesses.
// Copy alternates read and write per word; fill issues back-to-back writes of a constant.
module dcache_dma #(
  parameter int unsigned PC_BITS  = 16,
  parameter int unsigned LEN_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [PC_BITS-1:0]  src_i,
  input  logic [PC_BITS-1:0]  dst_i,
  input  logic [LEN_BITS-1:0] len_i,
  input  logic [PC_BITS-1:0]  pattern_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                cache_en_o,
  output logic                write_read_o,
  output logic [PC_BITS-1:0]  addr_o,
  output logic [PC_BITS-1:0]  data_o,
  input  logic [PC_BITS-1:0]  data_i
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StFill, StDone} state_e;

  state_e              state_q, state_d;
  logic [PC_BITS-1:0]  src_q, src_d;
  logic [PC_BITS-1:0]  dst_q, dst_d;
  logic [PC_BITS-1:0]  buf_q, buf_d;
  logic [PC_BITS-1:0]  pat_q, pat_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;

  logic last_word;
  assign last_word = (cnt_q == LEN_BITS'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    buf_d        = buf_q;
    pat_d        = pat_q;
    cnt_d        = cnt_q;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    cache_en_o   = 1'b0;
    write_read_o = 1'b0;
    addr_o       = '0;
    data_o       = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          src_d = src_i;
          dst_d = dst_i;
          cnt_d = len_i;
          pat_d = pattern_i;
          // Mode is carried by which active state is entered.
          if (len_i == '0) begin
            state_d = StDone;
          end else if (mode_i) begin
            state_d = StFill;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        busy_o     = 1'b1;
        cache_en_o = 1'b1;
        addr_o     = src_q;
        buf_d      = data_i;
        src_d      = src_q + PC_BITS'(1);
        state_d    = abort_i ? StDone : StWr;
      end
      StWr: begin
        busy_o       = 1'b1;
        cache_en_o   = 1'b1;
        write_read_o = 1'b1;
        addr_o       = dst_q;
        data_o       = buf_q;
        dst_d        = dst_q + PC_BITS'(1);
        cnt_d        = cnt_q - LEN_BITS'(1);
        state_d      = (abort_i || last_word) ? StDone : StRd;
      end
      StFill: begin
        busy_o       = 1'b1;
        cache_en_o   = 1'b1;
        write_read_o = 1'b1;
        addr_o       = dst_q;
        data_o       = pat_q;
        dst_d        = dst_q + PC_BITS'(1);
        cnt_d        = cnt_q - LEN_BITS'(1);
        state_d      = (abort_i || last_word) ? StDone : StFill;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dcache_dma.sv
// Bench for dcache_dma: a behavioural cache memory, a schedule-based transfer model checked
// every cycle, and directed scenarios with hand-computed literal expectations.
module tb_dcache_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] src = '0;
  logic [15:0] dst = '0;
  logic [15:0] len = '0;
  logic [15:0] pattern = '0;
  logic        abort = 1'b0;
  logic        busy, done, cache_en, write_read;
  logic [15:0] addr, data_out, data_in;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  dcache_dma #(.PC_BITS(16), .LEN_BITS(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .mode_i      (mode),
    .src_i       (src),
    .dst_i       (dst),
    .len_i       (len),
    .pattern_i   (pattern),
    .abort_i     (abort),
    .busy_o      (busy),
    .done_o      (done),
    .cache_en_o  (cache_en),
    .write_read_o(write_read),
    .addr_o      (addr),
    .data_o      (data_out),
    .data_i      (data_in)
  );

  // Data cache stand-in: combinational read, write on the rising edge.
  assign data_in = mem[addr];
  always @(posedge clk) if (cache_en && write_read) mem[addr] <= data_out;

  // Transfer model: cycle m_c (1-based after acceptance) maps directly to an access.
  bit          m_active = 1'b0;
  bit          m_mode = 1'b0;
  int          m_c = 0;
  int          m_end = 0;
  logic [15:0] m_src = '0, m_dst = '0, m_pat = '0, m_rdval = '0;

  function automatic void model_out(output logic b, output logic d, output logic e,
                                    output logic w, output logic [15:0] a,
                                    output logic [15:0] dd);
    int k;
    b = 0; d = 0; e = 0; w = 0; a = '0; dd = '0;
    if (m_active) begin
      if (m_c == m_end) begin
        d = 1;
      end else begin
        b = 1;
        e = 1;
        if (!m_mode) begin
          k = (m_c - 1) / 2;
          if (m_c % 2 == 1) begin
            a = m_src + 16'(k);
          end else begin
            w = 1; a = m_dst + 16'(k); dd = m_rdval;
          end
        end else begin
          w = 1; a = m_dst + 16'(m_c - 1); dd = m_pat;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    logic b, d, e, w;
    logic [15:0] a, dd;
    model_out(b, d, e, w, a, dd);
    if (e) begin
      if (w) ref_mem[a] = dd;
      else   m_rdval = ref_mem[a];
    end
    if (rst) begin
      m_active = 0;
    end else if (m_active) begin
      if (m_c == m_end) m_active = 0;
      else begin
        if (abort) m_end = m_c + 1;
        m_c++;
      end
    end else if (start) begin
      m_active = 1;
      m_mode = mode;
      m_src = src; m_dst = dst; m_pat = pattern;
      m_c = 1;
      m_end = (len == 0) ? 1 : (mode ? int'(len) + 1 : 2 * int'(len) + 1);
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_acc = 0;
  int acc_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = -1;
  logic [15:0] wr_log[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic compare_cycle();
    logic b, d, e, w;
    logic [15:0] a, dd;
    model_out(b, d, e, w, a, dd);
    check("outputs", {busy, done, cache_en, write_read, addr, data_out, 10'd0},
          {b, d, e, w, a, dd, 10'd0});
    if (cache_en) begin
      acc_cnt++;
      if (write_read) begin
        wr_cnt++;
        wr_log.push_back(addr);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_mon();
    acc_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    wr_log.delete();
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic start_xfer(input logic md, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] n, input logic [15:0] p);
    clear_mon();
    mode = md; src = s; dst = d; len = n; pattern = p;
    start = 1'b1;
    tick();
    start = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    check("done_seen", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 8; i++) poke(16'h0100 + 16'(i), 16'h00A0 + 16'(i));

    repeat (2) @(posedge clk);
    #1;
    tick();
    check("reset_outputs", {busy, done, cache_en, write_read, addr, data_out}, '0);
    rst = 1'b0;
    tick();

    // Copy 4 words.
    start_xfer(1'b0, 16'h0100, 16'h0200, 16'd4, 16'h0);
    wait_done(20);
    check("copy_done_lat", 32'(done_cyc - t_acc + 1), 32'd9);
    check("copy_accesses", 32'(acc_cnt), 32'd8);
    check("copy_writes", 32'(wr_cnt), 32'd4);
    for (int i = 0; i < 4; i++)
      check("copy_mem", 32'(mem[16'h0200 + 16'(i)]), 32'h00A0 + 32'(i));

    // Fill 3 words.
    start_xfer(1'b1, 16'h0000, 16'h0300, 16'd3, 16'hBEEF);
    wait_done(20);
    check("fill_done_lat", 32'(done_cyc - t_acc + 1), 32'd4);
    check("fill_writes", 32'(wr_cnt), 32'd3);
    check("fill_accesses", 32'(acc_cnt), 32'd3);
    for (int i = 0; i < 3; i++) check("fill_mem", 32'(mem[16'h0300 + 16'(i)]), 32'hBEEF);
    check("fill_mem_after", 32'(mem[16'h0303]), 32'h0);

    // Zero length.
    start_xfer(1'b0, 16'h0100, 16'h0800, 16'd0, 16'h0);
    wait_done(5);
    check("len0_done_lat", 32'(done_cyc - t_acc + 1), 32'd1);
    check("len0_accesses", 32'(acc_cnt), 32'd0);
    check("len0_mem", 32'(mem[16'h0800]), 32'h0);

    // Fill across the top of the address space.
    start_xfer(1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h5A5A);
    wait_done(20);
    check("wrap_count", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      check("wrap_a0", 32'(wr_log[0]), 32'hFFFE);
      check("wrap_a1", 32'(wr_log[1]), 32'hFFFF);
      check("wrap_a2", 32'(wr_log[2]), 32'h0000);
      check("wrap_a3", 32'(wr_log[3]), 32'h0001);
    end
    // Restore low words clobbered by the wrap so later checks see zeros.
    poke(16'h0000, 16'h0); poke(16'h0001, 16'h0);

    // Abort during the third write (cycle T+6).
    start_xfer(1'b0, 16'h0100, 16'h0600, 16'd8, 16'h0);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(5);
    check("abort_done_lat", 32'(done_cyc - t_acc + 1), 32'd7);
    check("abort_writes", 32'(wr_cnt), 32'd3);
    check("abort_mem2", 32'(mem[16'h0602]), 32'h00A2);
    check("abort_mem3", 32'(mem[16'h0603]), 32'h0);

    // Reset during the third write.
    start_xfer(1'b0, 16'h0100, 16'h0700, 16'd8, 16'h0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_idle", {busy, done, cache_en, write_read, addr, data_out}, '0);
    repeat (6) tick();
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_writes", 32'(wr_cnt), 32'd3);
    check("rst_mem3", 32'(mem[16'h0703]), 32'h0);

    // Start pulsed while busy must be ignored.
    start_xfer(1'b0, 16'h0100, 16'h0400, 16'd4, 16'h0);
    tick();
    mode = 1'b1; dst = 16'h0500; len = 16'd2; pattern = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20);
    repeat (6) tick();
    check("ign_done_cnt", 32'(done_cnt), 32'd1);
    check("ign_accesses", 32'(acc_cnt), 32'd8);
    check("ign_mem3", 32'(mem[16'h0403]), 32'h00A3);
    check("ign_mem_fill", 32'(mem[16'h0500]), 32'h0);

    // Overlapping ascending copy replicates the first source word.
    poke(16'h0010, 16'h0005);
    poke(16'h0011, 16'h1111); poke(16'h0012, 16'h2222); poke(16'h0013, 16'h3333);
    start_xfer(1'b0, 16'h0010, 16'h0011, 16'd3, 16'h0);
    wait_done(20);
    for (int i = 1; i <= 3; i++) check("overlap_mem", 32'(mem[16'h0010 + 16'(i)]), 32'h5);
    check("overlap_mem4", 32'(mem[16'h0014]), 32'h0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_dma.md
# dcache_dma

Block-transfer engine that masters the data-cache port. On a start request it either copies N words from a source address to a destination address, or fills N words with a constant pattern, by issuing single-word accesses over the same enable/write-read/address/data interface the data cache exposes. It sits beside the CPU memory stage and shares that data-cache port with it; the shared-port arbiter grants the port only while `busy_o` is high.

## Interface
- `PC_BITS`, 16, address and data width; must match the data cache.
- `LEN_BITS`, 16, width of the transfer-length field.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  start request; sampled only in IDLE.
- `mode_i`  in  1  0 = copy, 1 = fill; sampled with `start_i`.
- `src_i`  in  PC_BITS  copy source base address.
- `dst_i`  in  PC_BITS  destination base address (copy and fill).
- `len_i`  in  LEN_BITS  word count N; 0 is legal.
- `pattern_i`  in  PC_BITS  fill value.
- `abort_i`  in  1  stop the transfer at the next edge.
- `busy_o`  out  1  high from the cycle after acceptance until DONE.
- `done_o`  out  1  one-cycle completion pulse.
- `cache_en_o`  out  1  data-cache access enable.
- `write_read_o`  out  1  1 = write, 0 = read.
- `addr_o`  out  PC_BITS  data-cache address.
- `data_o`  out  PC_BITS  write data to the data cache.
- `data_i`  in  PC_BITS  read data from the data cache; combinational, valid in the same cycle as the read.

## Operation
- States: IDLE, RD, WR, FILL, DONE.
- IDLE
  - `start_i` = 1 latches `src_i`, `dst_i`, `len_i`, `mode_i` and `pattern_i` into internal registers.
  - `len_i` = 0 goes to DONE.
  - Otherwise copy goes to RD and fill goes to FILL.
- RD drives `cache_en_o`=1, `write_read_o`=0 and `addr_o`=src pointer.
  - At the edge: capture `data_i` into the word buffer, increment the src pointer, go to WR.
- WR drives `cache_en_o`=1, `write_read_o`=1, `addr_o`=dst pointer and `data_o`=buffer.
  - At the edge: increment the dst pointer and decrement the remaining count.
  - If the remaining count was 1, go to DONE; else go to RD.
- FILL drives `cache_en_o`=1, `write_read_o`=1, `addr_o`=dst pointer and `data_o`=pattern.
  - At the edge: increment the dst pointer and decrement the remaining count.
  - If the remaining count was 1, go to DONE; else stay in FILL.
- DONE asserts `done_o`=1 and `busy_o`=0 for one cycle, then returns to IDLE.
- Address arithmetic is modulo 2^PC_BITS. The pointer after 0xFFFF is 0x0000.
- Copy is strictly word-by-word ascending: read k, then write k. Overlap with dst > src therefore replicates source words; this is required behaviour.
- `start_i` outside IDLE is ignored; it is not queued.
- `abort_i` in RD, WR or FILL goes to DONE at the next edge.
  - An access driven in the abort cycle still completes, because the cache samples on that edge.
  - `abort_i` in IDLE or DONE has no effect.
- Outside RD, WR and FILL: `cache_en_o`, `write_read_o`, `addr_o` and `data_o` are all 0.

## Timing
- Reset: state = IDLE, all pointers, count and buffer = 0. Every output is 0.
- Reset has priority over every other input. Reset mid-transfer returns to IDLE at that edge with no `done_o` pulse. Writes already performed are not undone.
- Start accepted at edge T:
  - `busy_o` is high from cycle T+1.
  - Copy word k (0-based): read in cycle T+1+2k, written in cycle T+2+2k.
  - Copy completion: DONE/`done_o` in cycle T+1+2N.
  - Fill word k: written in cycle T+1+k. Fill completion: `done_o` in cycle T+1+N.
  - `len_i` = 0: `done_o` in cycle T+1, with no cache access.
- The earliest next start is accepted in the cycle after DONE, at edge T+2+2N for copy.
- Maximum N is 2^LEN_BITS − 1. The count register is LEN_BITS wide and never wraps.

## Test plan
- Copy: preload mem[0x0100..0x0103] = 0xA0,0xA1,0xA2,0xA3; start with src=0x0100, dst=0x0200, len=4, mode=0.
  - Required: mem[0x0200..0x0203] = 0xA0..0xA3.
  - Required: `done_o` pulses 9 cycles after acceptance; exactly 8 cache accesses with alternating R/W.
- Fill: start with dst=0x0300, len=3, pattern=0xBEEF, mode=1.
  - Required: mem[0x0300..0x0302] = 0xBEEF.
  - Required: `done_o` 4 cycles after acceptance; `write_read_o` = 1 on all 3 accesses.
- len=0 with start: required `done_o` at T+1, `cache_en_o` never asserted, memory unchanged.
- Wrap: fill with dst=0xFFFE, len=4.
  - Required: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001 in that order.
- Abort/reset:
  - Copy len=8; assert `abort_i` in the cycle of the 3rd write. Required: exactly 3 words written, `done_o` in the next cycle.
  - Repeat with `rst_i` instead of `abort_i`. Required: IDLE, all outputs 0, no `done_o` pulse.
- Ignored start and overlap:
  - Pulse `start_i` with new arguments while busy. Required: the current transfer is unaffected, and no second transfer starts.
  - Copy src=0x0010, dst=0x0011, len=3 with mem[0x10] = 0x5. Required: mem[0x11..0x13] = 0x5.
